// File: rtl/avg_sram_ctrl.sv
// Moving-average sequencer over a circular SRAM window of the last 2**ADDR_BITS prices.
// Clears the SRAM after reset, then does read-oldest / accumulate / overwrite per sample.
module avg_sram_ctrl #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    stock_price,
    input  logic                 data_ready,
    output logic                 busy,
    output logic                 overrun,
    output logic [DATA_W-1:0]    average,
    output logic                 avg_valid,
    output logic                 filled,
    output logic                 sram_read_enable,
    output logic                 sram_write_enable,
    output logic [ADDR_BITS-1:0] sram_address,
    output logic [DATA_W-1:0]    sram_write_data,
    input  logic [DATA_W-1:0]    sram_read_data
);

    localparam int SUM_W = ADDR_BITS + DATA_W;

    typedef enum logic [2:0] {
        CLR,
        IDLE,
        RD,
        ACC,
        WR
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   clr_addr_q, clr_addr_d;
    logic [ADDR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0]   count_q, count_d;
    logic [SUM_W-1:0]       sum_q, sum_d;
    logic [DATA_W-1:0]      price_q, price_d;
    logic [DATA_W-1:0]      average_q, average_d;
    logic                   avg_valid_q, avg_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   filled_q, filled_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLR;
            clr_addr_q  <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            sum_q       <= '0;
            price_q     <= '0;
            average_q   <= '0;
            avg_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            filled_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            price_q     <= price_d;
            average_q   <= average_d;
            avg_valid_q <= avg_valid_d;
            overrun_q   <= overrun_d;
            filled_q    <= filled_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        clr_addr_d        = clr_addr_q;
        wr_ptr_d          = wr_ptr_q;
        count_d           = count_q;
        sum_d             = sum_q;
        price_d           = price_q;
        average_d         = average_q;
        avg_valid_d       = 1'b0;
        overrun_d         = 1'b0;
        filled_d          = filled_q;
        sram_read_enable  = 1'b0;
        sram_write_enable = 1'b0;
        sram_address      = '0;
        sram_write_data   = '0;

        unique case (state_q)
            CLR: begin
                sram_write_enable = 1'b1;
                sram_address      = clr_addr_q;
                clr_addr_d        = clr_addr_q + 1'b1;
                if (clr_addr_q == '1) state_d = IDLE;
            end
            IDLE: begin
                if (data_ready) begin
                    price_d = stock_price;
                    state_d = RD;
                end
            end
            RD: begin
                sram_read_enable = 1'b1;
                sram_address     = wr_ptr_q;
                state_d          = ACC;
            end
            ACC: begin
                // The oldest entry is always part of sum_q, so this never wraps
                sum_d   = sum_q - SUM_W'(sram_read_data) + SUM_W'(price_q);
                state_d = WR;
            end
            WR: begin
                sram_write_enable = 1'b1;
                sram_address      = wr_ptr_q;
                sram_write_data   = price_q;
                wr_ptr_d          = wr_ptr_q + 1'b1;
                average_d         = sum_q[ADDR_BITS +: DATA_W];
                avg_valid_d       = 1'b1;
                if (!filled_q) begin
                    count_d = count_q + 1'b1;
                    if (count_q == '1) filled_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = CLR;
        endcase

        if (data_ready && state_q != IDLE) overrun_d = 1'b1;
    end

    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;
    assign average   = average_q;
    assign avg_valid = avg_valid_q;
    assign filled    = filled_q;

endmodule

// File: tb/tb_avg_sram_ctrl.sv
// Self-checking bench for avg_sram_ctrl: vector table, directed corner cases and
// random prices checked against an array-based window-average model.
module tb_avg_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] stock_price;
    logic        data_ready;
    logic        busy;
    logic        overrun;
    logic [31:0] average;
    logic        avg_valid;
    logic        filled;
    logic        sram_read_enable;
    logic        sram_write_enable;
    logic [4:0]  sram_address;
    logic [31:0] sram_write_data;
    logic [31:0] sram_read_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    avg_sram_ctrl #(.ADDR_BITS(5), .DATA_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .stock_price      (stock_price),
        .data_ready       (data_ready),
        .busy             (busy),
        .overrun          (overrun),
        .average          (average),
        .avg_valid        (avg_valid),
        .filled           (filled),
        .sram_read_enable (sram_read_enable),
        .sram_write_enable(sram_write_enable),
        .sram_address     (sram_address),
        .sram_write_data  (sram_write_data),
        .sram_read_data   (sram_read_data)
    );

    // Behavioural single-port SRAM, one-cycle read latency
    logic [31:0] sram_mem [32];
    always @(posedge clk) begin
        if (sram_write_enable) sram_mem[sram_address] <= sram_write_data;
        if (sram_read_enable) sram_read_data <= sram_mem[sram_address];
    end

    // Reference model: the window as a plain array, average = sum / 32
    longint unsigned mdl_mem [32];
    int              mdl_wp;
    int              mdl_cnt;
    int              last_rd_addr;

    typedef struct {
        logic [31:0] price;
        logic [31:0] exp_avg;
        logic        exp_filled;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl_mem[i] = 0;
        mdl_wp  = 0;
        mdl_cnt = 0;
    endtask

    function automatic logic [31:0] model_avg();
        longint unsigned s = 0;
        for (int i = 0; i < 32; i++) s += mdl_mem[i];
        return 32'(s / 32);
    endfunction

    task automatic clear_sweep();
        for (int i = 0; i < 32; i++) begin
            check($sformatf("clr_cycle%0d", i),
                  {26'd0, sram_write_enable, sram_read_enable, busy,
                   sram_address, sram_write_data},
                  {26'd0, 1'b1, 1'b0, 1'b1, 5'(i), 32'd0});
            tick();
        end
        check("clr_done_busy", busy, 0);
        check("clr_done_avg", average, 0);
        check("clr_done_filled", filled, 0);
        model_reset();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        data_ready = 1'b0;
        tick();
        tick();
        check("rst_state",
              {avg_valid, overrun, filled, busy, average},
              {1'b0, 1'b0, 1'b0, 1'b1, 32'd0});
        rst = 1'b0;
        clear_sweep();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    task automatic send_sample(input logic [31:0] p);
        logic [31:0] exp_avg;
        int          a;
        wait_idle();
        stock_price = p;
        data_ready  = 1'b1;
        tick();
        data_ready  = 1'b0;
        stock_price = $urandom;
        a = mdl_wp;
        last_rd_addr = a;
        mdl_mem[a] = longint'(p);
        mdl_wp  = (mdl_wp + 1) % 32;
        mdl_cnt++;
        exp_avg = model_avg();
        check("rd_cycle",
              {29'd0, sram_read_enable, sram_write_enable, overrun,
               avg_valid, sram_address},
              {29'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'(a)});
        tick();
        check("acc_cycle", {sram_read_enable, sram_write_enable}, 0);
        tick();
        check("wr_cycle",
              {sram_read_enable, sram_write_enable, sram_address,
               sram_write_data},
              {1'b0, 1'b1, 5'(a), p});
        tick();
        check("avg_out",
              {avg_valid, busy, filled, average},
              {1'b1, 1'b0, mdl_cnt >= 32, exp_avg});
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        data_ready  = 1'b0;
        stock_price = '0;

        vecs[0] = '{32'd32,         32'd1,         1'b0};
        vecs[1] = '{32'd64,         32'd3,         1'b0};
        vecs[2] = '{32'd1000,       32'd34,        1'b0};
        vecs[3] = '{32'hFFFF_FFFF,  32'd134217762, 1'b0};

        // Reset, clear sweep, then the vector table
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            send_sample(vecs[i].price);
            check($sformatf("vec%0d", i), {filled, average},
                  {vecs[i].exp_filled, vecs[i].exp_avg});
        end

        // Fill and wrap
        reset_dut();
        for (int i = 0; i < 32; i++) send_sample(32'd100);
        check("fill_avg", {filled, average}, {1'b1, 32'd100});
        send_sample(32'd132);
        check("wrap_rd_addr", last_rd_addr, 0);
        check("wrap_avg", average, 101);

        // Overrun: second strobe lands in ACC
        reset_dut();
        stock_price = 32'd320;
        data_ready  = 1'b1;
        tick();
        data_ready  = 1'b0;
        tick();
        stock_price = 32'd9999;
        data_ready  = 1'b1;
        tick();
        data_ready  = 1'b0;
        check("ovr_pulse", {overrun, avg_valid}, {1'b1, 1'b0});
        tick();
        check("ovr_result", {overrun, avg_valid, average},
              {1'b0, 1'b1, 32'd10});
        tick();
        check("ovr_single_valid", {avg_valid, busy, overrun}, 0);
        mdl_mem[0] = 320;
        mdl_wp  = 1;
        mdl_cnt = 1;
        send_sample(32'd32);
        check("ovr_next_avg", average, 11);

        // Extreme values
        reset_dut();
        for (int i = 0; i < 32; i++) send_sample(32'hFFFF_FFFF);
        check("ext_max", average, 32'hFFFF_FFFF);
        for (int i = 0; i < 32; i++) send_sample(32'd0);
        check("ext_zero", average, 0);

        // Reset in ACC after 5 samples
        reset_dut();
        for (int i = 0; i < 5; i++) send_sample(32'd500);
        stock_price = 32'd777;
        data_ready  = 1'b1;
        tick();
        data_ready  = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("midrst_regs",
              {avg_valid, overrun, filled, busy, average},
              {1'b0, 1'b0, 1'b0, 1'b1, 32'd0});
        rst = 1'b0;
        clear_sweep();
        send_sample(32'd64);
        check("midrst_avg", average, 2);

        // Random prices with random idle gaps
        reset_dut();
        for (int i = 0; i < 150; i++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            send_sample($urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
